// File: rtl/regfile_reader.sv
// Read-side sequencer for the CPU register bank: accepts a two-operand read request,
// fetches both operands (with write-through bypass) and returns one registered response.
module regfile_reader #(
  parameter int DATA_W    = 14,
  parameter int NUM_REGS  = 8,
  parameter int IDX_W     = 3,
  parameter int DUAL_PORT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REGS*DATA_W-1:0] bank_data,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [IDX_W-1:0]           req_idx_a,
  input  logic [IDX_W-1:0]           req_idx_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data_a,
  output logic [DATA_W-1:0]          rsp_data_b,
  output logic                       rsp_err
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // READ_A | fetch operand A (and B when dual-ported) at the next edge
  // READ_B | fetch operand B at the next edge
  // RESP   | response presented until the consumer takes it
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ_A = 2'd1;
  localparam logic [1:0] READ_B = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx_a;
  logic [IDX_W-1:0]  idx_b;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  logic              ok_a;
  logic              ok_b;

  // Out-of-range indices match no slice and never match the bypass, so they read 0.
  function automatic logic [DATA_W-1:0] fetch(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) begin
        if (wr_en && (wr_idx == idx)) v = wr_data;
        else                           v = bank_data[i*DATA_W +: DATA_W];
      end
    end
    return v;
  endfunction

  always_comb begin
    val_a = fetch(idx_a);
    val_b = fetch(idx_b);
    ok_a  = {1'b0, idx_a} < NUM_REGS_W;
    ok_b  = {1'b0, idx_b} < NUM_REGS_W;
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx_a      <= '0;
      idx_b      <= '0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx_a   <= req_idx_a;
            idx_b   <= req_idx_b;
            rsp_err <= 1'b0;
            state   <= READ_A;
          end
        end
        READ_A: begin
          rsp_data_a <= val_a;
          if (DUAL_PORT != 0) begin
            rsp_data_b <= val_b;
            rsp_err    <= rsp_err | ~ok_a | ~ok_b;
            state      <= RESP;
          end else begin
            rsp_err <= rsp_err | ~ok_a;
            state   <= READ_B;
          end
        end
        READ_B: begin
          rsp_data_b <= val_b;
          rsp_err    <= rsp_err | ~ok_b;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: single-port and dual-port instances with a 6-register bank,
// directed scenarios plus random requests and writes checked against a bank model.
module tb_regfile_reader;
  localparam int DW = 14;
  localparam int NR = 6;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*DW-1:0] bank_data;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [DW-1:0]    wr_data;
  logic             req_valid [2];
  logic             req_ready [2];
  logic [IW-1:0]    req_idx_a [2];
  logic [IW-1:0]    req_idx_b [2];
  logic             rsp_valid [2];
  logic             rsp_ready [2];
  logic [DW-1:0]    rsp_data_a [2];
  logic [DW-1:0]    rsp_data_b [2];
  logic             rsp_err [2];

  logic [DW-1:0] regs [NR];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    bank_data = '0;
    for (int i = 0; i < NR; i++) bank_data[i*DW +: DW] = regs[i];
  end

  regfile_reader #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW), .DUAL_PORT(0)) u_sp (
    .clk(clk), .rst(rst), .bank_data(bank_data), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_idx_a(req_idx_a[0]), .req_idx_b(req_idx_b[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_data_a(rsp_data_a[0]), .rsp_data_b(rsp_data_b[0]),
    .rsp_err(rsp_err[0]));

  regfile_reader #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW), .DUAL_PORT(1)) u_dp (
    .clk(clk), .rst(rst), .bank_data(bank_data), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_idx_a(req_idx_a[1]), .req_idx_b(req_idx_b[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_data_a(rsp_data_a[1]), .rsp_data_b(rsp_data_b[1]),
    .rsp_err(rsp_err[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // widx: -1 random write (any index, incl. nonexistent 6/7), -2 no write, else that index
  task automatic drive_wr(input int widx, input logic [DW-1:0] wd);
    if (widx == -1) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_idx  = IW'($urandom_range(0, 7));
      wr_data = DW'($urandom);
    end else if (widx == -2) begin
      wr_en = 1'b0;
    end else begin
      wr_en   = 1'b1;
      wr_idx  = IW'(widx);
      wr_data = wd;
    end
  endtask

  // Register value as it stands just after the coming edge; nonexistent registers read 0.
  function automatic logic [DW-1:0] post_val(input int idx);
    logic [DW-1:0] nxt [NR];
    nxt = regs;
    if (wr_en && wr_idx < NR) nxt[wr_idx] = wr_data;
    return (idx < NR) ? nxt[idx] : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (wr_en && wr_idx < NR) regs[wr_idx] = wr_data;
    @(negedge clk);
  endtask

  task automatic run_txn(input int d, input int ia, input int ib, input int wa,
                         input logic [DW-1:0] da, input int wb, input logic [DW-1:0] db,
                         input int hold);
    logic [DW-1:0] ea, eb;
    logic ee;
    chk("req_ready_idle", 32'(req_ready[d]), 1);
    req_valid[d] = 1'b1;
    req_idx_a[d] = IW'(ia);
    req_idx_b[d] = IW'(ib);
    rsp_ready[d] = (hold == 0);
    drive_wr(-1, '0);
    tick();
    req_valid[d] = 1'b0;
    req_idx_a[d] = IW'($urandom);
    req_idx_b[d] = IW'($urandom);
    chk("rsp_valid_early", 32'(rsp_valid[d]), 0);
    chk("req_ready_busy", 32'(req_ready[d]), 0);
    drive_wr(wa, da);
    ea = post_val(ia);
    eb = post_val(ib);
    tick();
    if (d == 0) begin
      chk("rsp_valid_early_b", 32'(rsp_valid[d]), 0);
      drive_wr(wb, db);
      eb = post_val(ib);
      tick();
    end
    ee = (ia >= NR) || (ib >= NR);
    chk("rsp_valid", 32'(rsp_valid[d]), 1);
    chk("data_a", 32'(rsp_data_a[d]), 32'(ea));
    chk("data_b", 32'(rsp_data_b[d]), 32'(eb));
    chk("err", 32'(rsp_err[d]), 32'(ee));
    for (int k = 0; k < hold; k++) begin
      drive_wr(-1, '0);
      tick();
      chk("hold_valid", 32'(rsp_valid[d]), 1);
      chk("hold_a", 32'(rsp_data_a[d]), 32'(ea));
      chk("hold_b", 32'(rsp_data_b[d]), 32'(eb));
      chk("hold_err", 32'(rsp_err[d]), 32'(ee));
      chk("hold_req_ready", 32'(req_ready[d]), 0);
    end
    rsp_ready[d] = 1'b1;
    drive_wr(-1, '0);
    tick();
    chk("rsp_valid_done", 32'(rsp_valid[d]), 0);
    chk("req_ready_done", 32'(req_ready[d]), 1);
    rsp_ready[d] = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_idx_a[d] = '0; req_idx_b[d] = '0; rsp_ready[d] = 1'b0;
    end
    for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
    regs[2] = 14'h1234;
    regs[5] = 14'h0ABC;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(rsp_valid[d]), 0);
      chk("rst_ready", 32'(req_ready[d]), 1);
      chk("rst_a", 32'(rsp_data_a[d]), 0);
      chk("rst_b", 32'(rsp_data_b[d]), 0);
      chk("rst_err", 32'(rsp_err[d]), 0);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      regs[2] = 14'h1234;
      regs[5] = 14'h0ABC;
      run_txn(d, 2, 5, -2, '0, -2, '0, 0);
      run_txn(d, 2, 5, 2, 14'h3FFF, 5, 14'h2222, 0);
      run_txn(d, 1, 1, -2, '0, 1, 14'h0001, 0);
      run_txn(d, 7, 0, -2, '0, -2, '0, 0);
      run_txn(d, 3, 4, -2, '0, -2, '0, 0);
      run_txn(d, 6, 6, 6, 14'h1555, 6, 14'h2AAA, 0);
      run_txn(d, 4, 2, -1, '0, -1, '0, 4);
      for (int n = 0; n < 25; n++)
        run_txn(d, $urandom_range(0, 7), $urandom_range(0, 7), -1, '0, -1, '0,
                $urandom_range(0, 3));
    end

    // reset while the single-port reader is in READ_B
    req_valid[0] = 1'b1; req_idx_a[0] = 3'd2; req_idx_b[0] = 3'd7;
    tick();
    req_valid[0] = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid[0]), 0);
    chk("midrst_a", 32'(rsp_data_a[0]), 0);
    chk("midrst_b", 32'(rsp_data_b[0]), 0);
    chk("midrst_err", 32'(rsp_err[0]), 0);
    chk("midrst_ready", 32'(req_ready[0]), 1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("postrst_valid", 32'(rsp_valid[0]), 0);
    run_txn(0, 0, 3, -1, '0, -1, '0, 1);
    run_txn(1, 5, 1, -1, '0, -1, '0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
